rot_seq_ctrl: RTL and testbench

Sequencing controller for the single-step 4-bit rotator datapath. It accepts a word, a rotate amount and a direction on a start strobe, then applies the one-position rotate stage once per clock until the requested amount is reached. It presents the result with a one-cycle `done` pulse. It sits between the rotator mux stage and any requester that needs multi-position rotation without cascading combinational stages.

---
 rtl/rot_pkg.sv | 16 +
 rtl/rot_step.sv | 37 +++
 rtl/rot_seq_ctrl.sv | 80 ++++++++
 tb/tb_rot_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared constants for the multi-cycle rotator: FSM encoding, direction codes
// and the default datapath width.
package rot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam int DEFAULT_W = 4;

endpackage

// File: rtl/rot_step.sv
// One-position rotator: every output bit is a 2:1 mux choosing between its
// left-hand and right-hand neighbour, with the direction code as the select.
module rot_mux2 (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module rot_step
  import rot_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] din,
  input  logic         dir,
  output logic [W-1:0] dout
);

  logic sel_right;
  assign sel_right = (dir == DIR_R);

  // Left rotate pulls from bit i-1, right rotate from bit i+1, both wrapping.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      rot_mux2 u_mux (
        .sel (sel_right),
        .a   (din[(gi + W - 1) % W]),
        .b   (din[(gi + 1) % W]),
        .y   (dout[gi])
      );
    end
  endgenerate

endmodule

// File: rtl/rot_seq_ctrl.sv
// Sequencing controller: captures a word/amount/direction on start and applies
// the single-step rotator once per clock until the amount is used up.
module rot_seq_ctrl
  import rot_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  din,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  dout
);

  state_t        state_reg, state_next;
  logic [W-1:0]  data_reg, data_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          dir_reg, dir_next;
  logic [W-1:0]  step_out;

  rot_step #(.W(W)) u_step (
    .din  (data_reg),
    .dir  (dir_reg),
    .dout (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= DIR_L;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request exactly like IDLE for back-to-back use.
        if (start) begin
          data_next  = din;
          cnt_next   = amt;
          dir_next   = dir;
          state_next = (amt == '0) ? ST_DONE : ST_ROT;
        end else if (state_reg == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end
      ST_ROT: begin
        data_next = step_out;
        cnt_next  = cnt_reg - AW'(1);
        if (cnt_reg == AW'(1)) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign busy  = (state_reg == ST_ROT);
  assign done  = (state_reg == ST_DONE);
  assign dout  = data_reg;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Bench for rot_seq_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a timestamp-based model of when each request finishes.
module tb_rot_seq_ctrl;
  localparam int W  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  din = '0;
  logic [AW-1:0] amt = '0;
  logic          dir = 1'b0;
  logic          ready, busy, done;
  logic [W-1:0]  dout;

  always #5 clk = ~clk;

  rot_seq_ctrl #(.W(W), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
    .dir   (dir),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotation by a whole amount at once, by shift arithmetic.
  function automatic int rot_ref(input int d, input int a, input bit r);
    int mask;
    mask = (1 << W) - 1;
    if (a == 0) return d & mask;
    if (!r) return ((d << a) | (d >> (W - a))) & mask;
    return ((d >> a) | (d << (W - a))) & mask;
  endfunction

  // Model: a request accepted at edge e with amount a is busy after edges
  // e..e+a-1, done after edge e+a, then idle holding the result.
  int  edge_k = 0;
  bit  op_active = 0;
  int  op_e = 0, op_amt = 0, op_res = 0;
  bit  exp_ready = 1, exp_busy = 0, exp_done = 0, exp_dout_chk = 1;
  int  exp_dout = 0;
  bit  model_live = 0;

  always @(posedge clk) begin
    edge_k++;
    if (rst) begin
      op_active = 0;
    end else if (start && exp_ready) begin
      op_active = 1;
      op_e      = edge_k;
      op_amt    = int'(amt);
      op_res    = rot_ref(int'(din), int'(amt), dir);
    end
    exp_busy     = 0;
    exp_done     = 0;
    exp_dout_chk = 1;
    exp_dout     = 0;
    if (op_active) begin
      if (edge_k < op_e + op_amt) begin
        exp_busy     = 1;
        exp_dout_chk = 0;
      end else if (edge_k == op_e + op_amt) begin
        exp_done = 1;
      end
      exp_dout = op_res;
    end
    exp_ready  = !exp_busy;
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("ready", 32'(ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("ready_xor_busy", 32'(ready ^ busy), 32'd1);
      if (exp_dout_chk) check("dout", 32'(dout), 32'(exp_dout));
    end
  end

  task automatic wait_done(output int j, output int nb);
    j  = 0;
    nb = 0;
    while (!done && j < 20) begin
      if (busy) nb++;
      @(posedge clk); #1;
      j++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] d, input int a, input bit r,
                        input int want, input string tag);
    int j, nb;
    @(posedge clk); #1;
    start = 1'b1; din = d; amt = AW'(a); dir = r;
    @(posedge clk); #1;
    start = 1'b0; din = W'($urandom); amt = AW'($urandom); dir = 1'($urandom);
    wait_done(j, nb);
    check({tag, "_latency"}, 32'(j + 1), 32'(a + 1));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(a));
    check({tag, "_dout"}, 32'(dout), 32'(want));
  endtask

  initial begin
    int j, nb, ndone;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;

    check("ref_l1", 32'(rot_ref(1, 1, 0)), 32'd2);
    check("ref_l3", 32'(rot_ref(1, 3, 0)), 32'd8);
    check("ref_r1", 32'(rot_ref(1, 1, 1)), 32'd8);
    check("ref_r2", 32'(rot_ref(11, 2, 1)), 32'd14);
    check("ref_a0", 32'(rot_ref(6, 0, 1)), 32'd6);

    run_op(4'b0001, 1, 1'b0, 4'b0010, "l1");
    run_op(4'b0001, 3, 1'b0, 4'b1000, "l3");
    run_op(4'b0001, 1, 1'b1, 4'b1000, "r1");
    run_op(4'b1011, 2, 1'b1, 4'b1110, "r2");
    run_op(4'b0110, 0, 1'b0, 4'b0110, "a0");

    // Start pulsed during ROT must be ignored.
    @(posedge clk); #1;
    start = 1'b1; din = 4'b0001; amt = 2'd3; dir = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; din = 4'b1111; amt = 2'd0; dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(j, nb);
    check("ignore_done_seen", 32'(done), 32'd1);
    check("ignore_dout", 32'(dout), 32'd8);

    // Start held in the DONE cycle: accepted with no IDLE gap.
    start = 1'b1; din = 4'b0011; amt = 2'd1; dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_nogap_busy", 32'(busy), 32'd1);
    wait_done(j, nb);
    check("b2b_latency", 32'(j + 1), 32'd2);
    check("b2b_dout", 32'(dout), 32'b1001);

    // Reset in the second ROT cycle aborts the request silently.
    @(posedge clk); #1;
    start = 1'b1; din = 4'b0001; amt = 2'd3; dir = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_dout", 32'(dout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op(4'b1001, 1, 1'b0, 4'b0011, "post_rst");

    // Random traffic, checked by the per-cycle model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 2) == 0);
      din   = W'($urandom);
      amt   = AW'($urandom);
      dir   = 1'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
